// File: rtl/scan_decoder.sv
// Registered N-to-2^N line decoder with direct and auto-scan modes.
// Scan mode strobes each line for DWELL cycles, then blanks for BLANK cycles.
module scan_decoder #(
  parameter int N          = 2,
  parameter int DWELL      = 4,
  parameter int BLANK      = 1,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_n,
  input  logic              mode,
  input  logic [N-1:0]      sel,
  output logic [2**N-1:0]   Q,
  output logic [N-1:0]      idx,
  output logic              busy,
  output logic              wrap
);

  localparam int M  = 2**N;
  localparam int MX = (DWELL > BLANK)
                    ? ((DWELL > 2) ? DWELL : 2)
                    : ((BLANK > 2) ? BLANK : 2);
  localparam int CW = $clog2(MX);

  localparam logic [CW-1:0] DLAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLAST = CW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [M-1:0]  INACT = (ACTIVE_LOW != 0) ? {M{1'b1}} : {M{1'b0}};

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    SCAN_ON,
    SCAN_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  idx_q, idx_d;
  logic [M-1:0]  q_q, q_d;
  logic          wrap_q, wrap_d;
  logic          on_d;
  logic          step;
  logic [M-1:0]  oh;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    on_d    = 1'b0;
    step    = 1'b0;
    oh      = '0;
    if (en_n) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (!mode) begin
      state_d = DIRECT;
      cnt_d   = '0;
      idx_d   = sel;
      on_d    = 1'b1;
    end else begin
      unique case (state_q)
        IDLE, DIRECT: begin
          state_d = SCAN_ON;
          cnt_d   = '0;
          idx_d   = sel;
          on_d    = 1'b1;
        end
        SCAN_ON: begin
          on_d = 1'b1;
          if (cnt_q != DLAST) begin
            cnt_d = cnt_q + CW'(1);
          end else if (BLANK > 0) begin
            state_d = SCAN_GAP;
            cnt_d   = '0;
            on_d    = 1'b0;
          end else begin
            cnt_d = '0;
            step  = 1'b1;
          end
        end
        SCAN_GAP: begin
          if (cnt_q != BLAST) begin
            cnt_d = cnt_q + CW'(1);
          end else begin
            state_d = SCAN_ON;
            cnt_d   = '0;
            on_d    = 1'b1;
            step    = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // Advancing past the last line rolls to 0 and flags the sweep boundary.
    if (step) begin
      idx_d  = idx_q + N'(1);
      wrap_d = &idx_q;
    end
    if (on_d) oh[idx_d] = 1'b1;
    q_d = oh ^ INACT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      q_q     <= INACT;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      q_q     <= q_d;
      wrap_q  <= wrap_d;
    end
  end

  assign Q    = q_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;
  assign busy = (state_q == SCAN_ON) || (state_q == SCAN_GAP);

endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
- Parametrised, registered successor to the 2-to-4 active-low decoder: N select bits drive 2^N output lines, with a selectable output polarity.
- Direct mode gives a registered decode of sel.
- Scan mode steps automatically through every output. Each line is held for DWELL cycles, followed by BLANK all-inactive cycles (break-before-make).
- Used as a row/digit strobe generator for multiplexed displays and keypad scanning.

Parameters:
- N, 2, select width; 1..6; output width M = 2^N.
- DWELL, 4, cycles each line is asserted in scan mode; >= 1.
- BLANK, 1, all-inactive cycles between scan steps; >= 0 (0 = no gap).
- ACTIVE_LOW, 1, 1: asserted line = 0, inactive = 1; 0: inverted.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en_n  input  1  active-low enable; high forces all outputs inactive.
- mode  input  1  0 = direct decode, 1 = auto-scan.
- sel  input  N  direct-mode index; scan-mode start index.
- Q  output  M  decoded lines, registered; Q[i] corresponds to index i.
- idx  output  N  index currently (or last) driven.
- busy  output  1  high while in SCAN_ON or SCAN_GAP.
- wrap  output  1  one-cycle pulse when the scan index rolls from M-1 to 0.

Behaviour:
- All outputs are registered. INACT means all Q bits are inactive (all 1 when ACTIVE_LOW=1).
- Reset, asynchronous: state=IDLE, Q=INACT, idx=0, busy=0, wrap=0, dwell counter=0. Values change immediately on rst rising, not at the next clock edge.
- States: IDLE, DIRECT, SCAN_ON, SCAN_GAP. Each transition below is evaluated at a rising edge from the inputs sampled at that edge.
- Any state, en_n=1:
  - next state IDLE, Q=INACT, idx=0, busy=0, wrap=0.
  - en_n has priority over mode and sel.
- en_n=0, mode=0:
  - next state DIRECT, idx=sel, Q=onehot(sel) at the selected polarity.
  - Latency 1 cycle; sel is resampled every cycle.
- en_n=0, mode=1, current state IDLE or DIRECT:
  - next state SCAN_ON, idx=sel, cnt=0, Q asserts line sel.
  - wrap=0 on this entry, even when sel=0.
- SCAN_ON, while en_n=0 and mode=1:
  - cnt < DWELL-1: stay in SCAN_ON, cnt+1.
  - cnt == DWELL-1 and BLANK>0: go to SCAN_GAP, cnt=0, Q=INACT, idx unchanged.
  - cnt == DWELL-1 and BLANK=0: stay in SCAN_ON, idx=(idx+1) mod M, cnt=0.
- SCAN_GAP:
  - cnt < BLANK-1: stay in SCAN_GAP, cnt+1.
  - cnt == BLANK-1: go to SCAN_ON, idx=(idx+1) mod M, cnt=0.
- Scan period: DWELL+BLANK cycles per index; M*(DWELL+BLANK) cycles per full sweep.
- wrap is high exactly in the first SCAN_ON cycle after an increment from M-1 to 0; it is 0 at all other times.
- Mode change SCAN to DIRECT: takes effect at the next edge; the scan position is discarded. A return to scan restarts at sel.
- sel changes during scan are ignored until the next scan entry.
- Q never has more than one asserted bit. In SCAN_GAP, IDLE and reset it has zero asserted bits.
- Counter width is clog2(max(DWELL,BLANK,2)); no overflow is possible for legal parameters.

Test Plan:
All scenarios use N=2, DWELL=3, BLANK=1, ACTIVE_LOW=1 unless stated otherwise.
- Direct decode:
  - Stimulus: en_n=0, mode=0, sel stepped 0,1,2,3, one value per cycle.
  - Required: Q=1110, 1101, 1011, 0111, each one cycle after sel is applied; idx tracks sel; busy=0.
- Enable override:
  - Stimulus: scan running, then en_n=1 with mode=1, sel=2 held.
  - Required: at the next edge Q=1111, idx=0, busy=0, wrap=0; this holds for as long as en_n=1.
- Scan from sel=1:
  - Required Q sequence: 1101 x3, 1111, 1011 x3, 1111, 0111 x3, 1111, 1110 x3, 1111, 1101.
  - Period is 16 cycles; wrap=1 only in the first 1110 cycle; busy=1 throughout.
- BLANK=0, DWELL=1 instance:
  - Required: Q rotates 1110, 1101, 1011, 0111, 1110 on consecutive cycles.
  - Exactly one 0 in every cycle; wrap pulses once every 4 cycles.
- Mode switch mid-scan:
  - Stimulus: during the 1011 step set mode=0, sel=3.
  - Required: next cycle Q=0111, busy=0.
  - Stimulus: then mode=1 with sel=0.
  - Required: scan restarts with Q=1110 x3 and wrap=0.
- Async reset mid-scan:
  - Stimulus: assert rst between clock edges during SCAN_GAP.
  - Required: Q=1111, idx=0, busy=0 immediately, without waiting for a clock edge.
  - Stimulus: deassert rst with en_n=0, mode=1, sel=2.
  - Required: first edge after deassert gives Q=1011.
